if_pc_control: RTL and testbench
================================

IF_PC_CONTROL -- requirements
Module: IF_PC_Control

Interface
REQ-001 Parameter RESET_PC, default 32'd0, word index loaded into the PC on reset.
REQ-002 Parameter MEM_WORDS, default 1024, number of instruction-memory words; word indices at or above this value are out of range.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 Stall_IF  input  1  hazard hold; freezes the PC.
REQ-006 Branch_Taken_ID  input  1  taken-branch redirect request from ID.
REQ-007 Branch_Target_ID  input  32  branch target word index.
REQ-008 Jump_ID  input  1  jump redirect request from ID.
REQ-009 Jump_Target_ID  input  32  jump target word index.
REQ-010 PC_IF  output  32  current fetch word index, driven to the instruction memory.
REQ-011 PC_Plus1_IF  output  32  PC_IF+1, carried down the pipe for link and branch-offset use.
REQ-012 Valid_IF  output  1  the instruction fetched at PC_IF this cycle is on the correct path.
REQ-013 Flush_IF  output  1  the IF/ID register discards its contents this cycle.
REQ-014 Halted  output  1  fetch has run off the end of instruction memory.

Function
REQ-015 The PC is word-addressed and increments by 1; arithmetic is 32-bit unsigned, and 32'hFFFFFFFF+1 wraps to 0.
REQ-016 State machine states: RUN, REDIRECT, HALT; next-state priority is redirect > halt detect > stall > increment.
REQ-017 A redirect is Branch_Taken_ID or Jump_ID high at a rising edge; if both are high, Branch_Target_ID is used.
REQ-018 On a redirect at edge k, PC_IF equals the target after edge k, and the state is REDIRECT for exactly one cycle.
REQ-019 A redirect is taken in any state, including under Stall_IF and in HALT; it overrides the stall.
REQ-020 In REDIRECT: Flush_IF=1, Valid_IF=0, and the PC advances by 1 unless Stall_IF or a new redirect applies; next state is RUN, or REDIRECT again on a back-to-back redirect.
REQ-021 In RUN with Stall_IF=1 and no redirect: PC_IF, the state and Valid_IF hold, and Flush_IF=0.
REQ-022 In RUN: Valid_IF=1, Flush_IF=0, and PC_IF increments each unstalled cycle.
REQ-023 When PC_IF >= MEM_WORDS at an edge and no redirect is present, the state goes to HALT.
REQ-024 Halt detection overrides Stall_IF.
REQ-025 In HALT: PC_IF holds, Valid_IF=0, Flush_IF=0, Halted=1; the only exits are a redirect or reset.
REQ-026 A redirect to an out-of-range target is accepted (REDIRECT for one cycle) and enters HALT at the following edge.
REQ-027 PC_Plus1_IF is combinational from PC_IF in every state.
REQ-028 Stall_IF has no effect on Flush_IF.

Reset
REQ-029 When reset is high, asynchronously: PC_IF=RESET_PC, state=RUN, Valid_IF=1, Flush_IF=0, Halted=0.
REQ-030 Reset during REDIRECT or HALT discards the pending redirect.
REQ-031 Fetch resumes at RESET_PC on the first rising edge after reset deasserts; that edge increments the PC.

Structure
REQ-032 The state encoding (RUN=2'd0, REDIRECT=2'd1, HALT=2'd2) and the MEM_WORDS default belong in the shared pipeline package, since the IF/ID register and hazard unit reuse them.
REQ-033 Single module, no sub-modules.
REQ-034 The next-PC mux is one combinational block; the state and PC are one registered block with asynchronous reset.

Verification
REQ-035 Reset, then 4 unstalled edges -> PC_IF 0,1,2,3,4; Valid_IF=1; Flush_IF=0; PC_Plus1_IF=5 at end.
REQ-036 At PC_IF=6, Stall_IF high 3 cycles -> PC_IF stays 6 and Valid_IF=1 throughout; next unstalled edge gives 7.
REQ-037 At PC_IF=10, Branch_Taken_ID=1 with target 40 and Jump_ID=1 with target 80 -> PC_IF=40, Flush_IF=1 and Valid_IF=0 for one cycle, then 41 with Valid_IF=1.
REQ-038 Redirect with Stall_IF=1, target 20 -> PC_IF=20 and Flush_IF=1; while the stall persists the PC holds at 20.
REQ-039 Run to PC_IF=1023, 1 edge -> PC_IF=1024; next edge -> Halted=1, Valid_IF=0, PC holds; then Jump_ID with target 0 -> REDIRECT, then RUN at PC 1.
REQ-040 Assert reset asynchronously in the middle of a REDIRECT cycle -> outputs go to reset values immediately, with no Flush_IF pulse after release.

Source files
------------

// File: rtl/if_pc_control_pkg.sv
// ---------------------------------------------------------------------------
// if_pc_control_pkg
//
// Shared pipeline definitions for the fetch stage. The IF/ID register and the
// hazard unit also decode the fetch state, so the state encoding and the
// default instruction-memory size are kept here rather than in the IF block.
//
// Contents:
//   IF_RUN / IF_REDIRECT / IF_HALT  - fetch state encoding (2 bits)
//   IF_MEM_WORDS_DEFAULT            - default instruction-memory depth (words)
//   pc_out_of_range()               - true when a word index is past memory
// ---------------------------------------------------------------------------
package if_pc_control_pkg;

    // Fetch state encoding. Kept as plain constants so older blocks that
    // compare against raw 2-bit values keep working.
    localparam logic [1:0] IF_RUN      = 2'd0;
    localparam logic [1:0] IF_REDIRECT = 2'd1;
    localparam logic [1:0] IF_HALT     = 2'd2;

    // Default number of instruction-memory words.
    localparam int unsigned IF_MEM_WORDS_DEFAULT = 32'd1024;

    // A word index at or beyond the memory depth has run off the end of the
    // program. Both operands are 32-bit unsigned.
    function automatic logic pc_out_of_range(input logic [31:0] pc,
                                             input int unsigned mem_words);
        return (pc >= mem_words);
    endfunction

endpackage

// File: rtl/if_pc_control.sv
// ---------------------------------------------------------------------------
// if_pc_control
//
// Program-counter control for the instruction-fetch stage. The PC is a word
// index that normally advances by one per cycle. ID can redirect fetch with a
// taken branch or a jump; the hazard unit can freeze fetch with Stall_IF; and
// fetching past the end of instruction memory parks the stage in HALT until
// a redirect or reset.
//
// Parameters:
//   RESET_PC   - word index loaded on reset
//   MEM_WORDS  - instruction-memory depth in words
//
// Ports:
//   clk               in   clock, state updates on rising edge
//   reset             in   asynchronous active-high reset
//   Stall_IF          in   hazard hold, freezes the PC
//   Branch_Taken_ID   in   taken-branch redirect request
//   Branch_Target_ID  in   [31:0] branch target word index
//   Jump_ID           in   jump redirect request
//   Jump_Target_ID    in   [31:0] jump target word index
//   PC_IF             out  [31:0] current fetch word index
//   PC_Plus1_IF       out  [31:0] PC_IF + 1
//   Valid_IF          out  fetched instruction is on the correct path
//   Flush_IF          out  IF/ID register discards its contents
//   Halted            out  fetch has run off the end of memory
// ---------------------------------------------------------------------------
module if_pc_control
    import if_pc_control_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter int unsigned MEM_WORDS = IF_MEM_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall_IF,
    input  logic        Branch_Taken_ID,
    input  logic [31:0] Branch_Target_ID,
    input  logic        Jump_ID,
    input  logic [31:0] Jump_Target_ID,
    output logic [31:0] PC_IF,
    output logic [31:0] PC_Plus1_IF,
    output logic        Valid_IF,
    output logic        Flush_IF,
    output logic        Halted
);

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        redirect;
    logic [31:0] redirect_target;

    // Next-PC and next-state selection. Priority is redirect, then halt
    // detection, then stall, then increment. A redirect wins even in HALT and
    // under a stall; when branch and jump arrive together the branch target is
    // used. Halt detection looks at the current PC, so a redirect to an
    // out-of-range target still spends one cycle in REDIRECT before halting.
    // A stall in REDIRECT holds the PC but still returns to RUN, since the
    // flush has already been delivered.
    always_comb begin
        redirect        = Branch_Taken_ID | Jump_ID;
        redirect_target = Branch_Taken_ID ? Branch_Target_ID : Jump_Target_ID;
        pc_next         = pc;
        state_next      = state;

        if (redirect) begin
            pc_next    = redirect_target;
            state_next = IF_REDIRECT;
        end else if (pc_out_of_range(pc, MEM_WORDS)) begin
            state_next = IF_HALT;
        end else if (state == IF_HALT) begin
            state_next = IF_HALT;
        end else if (Stall_IF) begin
            state_next = IF_RUN;
        end else begin
            pc_next    = pc + 32'd1;
            state_next = IF_RUN;
        end
    end

    // State and PC register. Reset drops any pending redirect or halt and
    // restarts fetch at RESET_PC in RUN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IF_RUN;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    assign PC_IF       = pc;
    assign PC_Plus1_IF = pc + 32'd1;
    assign Valid_IF    = (state == IF_RUN);
    assign Flush_IF    = (state == IF_REDIRECT);
    assign Halted      = (state == IF_HALT);

endmodule

// File: tb/tb_if_pc_control.sv
// ---------------------------------------------------------------------------
// tb_if_pc_control
//
// Scoreboard bench for if_pc_control. The driver applies one cycle of inputs,
// steps a behavioural fetch model at the rising edge and queues the expected
// outputs; a monitor pops and compares on every falling edge. Directed
// scenarios are followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_if_pc_control;

    localparam int unsigned MEMW = 1024;

    typedef enum int {M_RUN, M_REDIR, M_HALT} mphase_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc1;
        logic        valid;
        logic        flush;
        logic        halted;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        Stall_IF;
    logic        Branch_Taken_ID;
    logic [31:0] Branch_Target_ID;
    logic        Jump_ID;
    logic [31:0] Jump_Target_ID;
    logic [31:0] PC_IF;
    logic [31:0] PC_Plus1_IF;
    logic        Valid_IF;
    logic        Flush_IF;
    logic        Halted;

    int tests;
    int fails;

    exp_t    exp_q[$];
    longint  m_pc;
    mphase_t m_phase;

    if_pc_control #(
        .RESET_PC (32'd0),
        .MEM_WORDS(MEMW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .Stall_IF        (Stall_IF),
        .Branch_Taken_ID (Branch_Taken_ID),
        .Branch_Target_ID(Branch_Target_ID),
        .Jump_ID         (Jump_ID),
        .Jump_Target_ID  (Jump_Target_ID),
        .PC_IF           (PC_IF),
        .PC_Plus1_IF     (PC_Plus1_IF),
        .Valid_IF        (Valid_IF),
        .Flush_IF        (Flush_IF),
        .Halted          (Halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it and reports a miss.
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)",
                     name, act, act, exp, exp);
        end
    endtask

    // Model reset: fetch starts over at word 0 on the correct path.
    function automatic void modelReset();
        m_pc    = 0;
        m_phase = M_RUN;
    endfunction

    // Behavioural fetch rules for one rising edge, applied to a 64-bit PC
    // that is folded back to 32 bits after each change.
    function automatic void modelEdge(input bit stall, input bit bt,
                                      input logic [31:0] btgt, input bit j,
                                      input logic [31:0] jtgt);
        if (bt || j) begin
            m_pc    = bt ? longint'(btgt) : longint'(jtgt);
            m_phase = M_REDIR;
        end else if (m_pc >= longint'(MEMW)) begin
            m_phase = M_HALT;
        end else if (m_phase == M_HALT || stall) begin
            if (m_phase != M_HALT) m_phase = M_RUN;
        end else begin
            m_pc    = (m_pc + 1) % 64'h1_0000_0000;
            m_phase = M_RUN;
        end
    endfunction

    function automatic exp_t modelOutputs();
        exp_t e;
        e.pc     = m_pc[31:0];
        e.pc1    = 32'((m_pc + 1) % 64'h1_0000_0000);
        e.valid  = (m_phase == M_RUN);
        e.flush  = (m_phase == M_REDIR);
        e.halted = (m_phase == M_HALT);
        return e;
    endfunction

    // Drive one cycle of inputs, let the edge happen, queue the prediction.
    task automatic applyStimulus(input bit stall, input bit bt,
                                 input logic [31:0] btgt, input bit j,
                                 input logic [31:0] jtgt);
        Stall_IF         = stall;
        Branch_Taken_ID  = bt;
        Branch_Target_ID = btgt;
        Jump_ID          = j;
        Jump_Target_ID   = jtgt;
        @(posedge clk);
        modelEdge(stall, bt, btgt, j, jtgt);
        exp_q.push_back(modelOutputs());
        #1;
        Stall_IF        = 1'b0;
        Branch_Taken_ID = 1'b0;
        Jump_ID         = 1'b0;
    endtask

    task automatic stepRun(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " pc"},     PC_IF,       32'd0);
        checkOutput({tag, " pc1"},    PC_Plus1_IF, 32'd1);
        checkOutput({tag, " valid"},  32'(Valid_IF), 32'd1);
        checkOutput({tag, " flush"},  32'(Flush_IF), 32'd0);
        checkOutput({tag, " halted"}, 32'(Halted),   32'd0);
    endtask

    // Monitor: compare the queued prediction away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("mon pc",     PC_IF,             e.pc);
                checkOutput("mon pc1",    PC_Plus1_IF,       e.pc1);
                checkOutput("mon valid",  32'(Valid_IF),     32'(e.valid));
                checkOutput("mon flush",  32'(Flush_IF),     32'(e.flush));
                checkOutput("mon halted", 32'(Halted),       32'(e.halted));
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        tests            = 0;
        fails            = 0;
        reset            = 1'b1;
        Stall_IF         = 1'b0;
        Branch_Taken_ID  = 1'b0;
        Branch_Target_ID = 32'd0;
        Jump_ID          = 1'b0;
        Jump_Target_ID   = 32'd0;
        modelReset();

        // Reset values, then release with no edge yet.
        #3;
        checkResetValues("reset");
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("release pc", PC_IF, 32'd0);

        // Four plain increments.
        for (int i = 1; i <= 4; i++) begin
            stepRun(1);
            checkOutput("inc pc", PC_IF, 32'(i));
            checkOutput("inc valid", 32'(Valid_IF), 32'd1);
        end
        checkOutput("inc pc1", PC_Plus1_IF, 32'd5);

        // Stall at 6 for three cycles.
        stepRun(2);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
            checkOutput("stall pc", PC_IF, 32'd6);
            checkOutput("stall valid", 32'(Valid_IF), 32'd1);
        end
        stepRun(1);
        checkOutput("unstall pc", PC_IF, 32'd7);

        // Branch and jump together at 10: branch target wins.
        stepRun(3);
        checkOutput("pre-branch pc", PC_IF, 32'd10);
        applyStimulus(1'b0, 1'b1, 32'd40, 1'b1, 32'd80);
        checkOutput("br pc", PC_IF, 32'd40);
        checkOutput("br flush", 32'(Flush_IF), 32'd1);
        checkOutput("br valid", 32'(Valid_IF), 32'd0);
        stepRun(1);
        checkOutput("br next pc", PC_IF, 32'd41);
        checkOutput("br next valid", 32'(Valid_IF), 32'd1);

        // Redirect under a stall, stall persists.
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 32'd20);
        checkOutput("stall-redir pc", PC_IF, 32'd20);
        checkOutput("stall-redir flush", 32'(Flush_IF), 32'd1);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        checkOutput("stall-hold pc", PC_IF, 32'd20);
        checkOutput("stall-hold flush", 32'(Flush_IF), 32'd0);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        checkOutput("stall-hold2 pc", PC_IF, 32'd20);

        // Run off the end of memory, halt, then jump back to 0.
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'd1020);
        stepRun(3);
        checkOutput("end pc", PC_IF, 32'd1023);
        stepRun(1);
        checkOutput("oor pc", PC_IF, 32'd1024);
        stepRun(1);
        checkOutput("halt flag", 32'(Halted), 32'd1);
        checkOutput("halt valid", 32'(Valid_IF), 32'd0);
        checkOutput("halt pc", PC_IF, 32'd1024);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        checkOutput("halt over stall", 32'(Halted), 32'd1);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'd0);
        checkOutput("unhalt flush", 32'(Flush_IF), 32'd1);
        checkOutput("unhalt pc", PC_IF, 32'd0);
        stepRun(1);
        checkOutput("unhalt run pc", PC_IF, 32'd1);
        checkOutput("unhalt run valid", 32'(Valid_IF), 32'd1);

        // Redirect to an out-of-range target: one REDIRECT cycle, then HALT.
        applyStimulus(1'b0, 1'b1, 32'd5000, 1'b0, 32'd0);
        checkOutput("oor redir flush", 32'(Flush_IF), 32'd1);
        stepRun(1);
        checkOutput("oor redir halt", 32'(Halted), 32'd1);

        // Async reset in the middle of a REDIRECT cycle.
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'd50);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkResetValues("mid-redir reset");
        modelReset();
        @(negedge clk);
        reset = 1'b0;
        stepRun(1);
        checkOutput("post-reset pc", PC_IF, 32'd1);
        checkOutput("post-reset flush", 32'(Flush_IF), 32'd0);

        // Randomized traffic, with targets clustered near the memory end.
        for (int i = 0; i < 400; i++) begin
            bit          st, bt, j;
            logic [31:0] bta, jta;
            st  = ($urandom_range(0, 99) < 30);
            bt  = ($urandom_range(0, 99) < 8);
            j   = ($urandom_range(0, 99) < 8);
            bta = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1015, 1030))
                                              : 32'($urandom_range(0, 1100));
            jta = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1015, 1030))
                                              : 32'($urandom_range(0, 1100));
            applyStimulus(st, bt, bta, j, jta);
        end

        // Let the monitor drain, bounded.
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        checkOutput("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
